can_rx_filter_fifo: RTL and testbench
=====================================

# can_rx_filter_fifo

Receive-side acceptance filter and frame buffer placed directly downstream of `can_rx`. It captures each completed frame (11-bit ID, 8-bit data) on the rising edge of the receiver's `valid`. It then applies a code/mask acceptance filter and stores accepted frames in a first-word-fall-through FIFO for the host to pop at its own pace. Overflow and rejected-frame statistics are kept for software diagnostics.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries; power of two, at least 2.
- `AW`, 2: pointer width, equal to log2(DEPTH).

Ports:
- `clk`, in, 1: single clock. All logic is rising-edge.
- `rst`, in, 1: synchronous, active-high reset.
- `in_id`, in, 11: frame ID from `can_rx`.
- `in_data`, in, 8: frame data byte from `can_rx`.
- `in_valid`, in, 1: frame-ready from `can_rx`. May be a pulse or held level; only its rising edge matters.
- `acc_code`, in, 11: acceptance code.
- `acc_mask`, in, 11: acceptance mask. A bit value of 1 means the ID bit must equal the corresponding `acc_code` bit; 0 means don't care.
- `pop`, in, 1: host consumes the head entry.
- `out_id`, out, 11: ID of the head entry. Reads 0 when the FIFO is empty.
- `out_data`, out, 8: data of the head entry. Reads 0 when the FIFO is empty.
- `out_valid`, out, 1: FIFO not empty.
- `count`, out, AW+1: number of stored entries, 0..DEPTH.
- `overflow`, out, 1: sticky flag, set when an accepted frame is dropped.
- `clr_ovf`, in, 1: clears `overflow`.
- `rej_cnt`, out, 8: count of frames rejected by the filter; saturates at 255.

## Operation
- Edge detect:
  - `v_d` is a registered copy of `in_valid`; reset value 0.
  - `cap = in_valid & ~v_d`.
  - If `in_valid` is held high across reset release, it yields exactly one capture.
  - A level held for many cycles yields exactly one capture.
- Filter: `hit = ((in_id ^ acc_code) & acc_mask) == 0`, evaluated combinationally in the `cap` cycle.
  - `acc_mask = 0` accepts every frame.
  - `acc_code` and `acc_mask` are sampled only in the `cap` cycle, so changing them never affects frames already stored.
- `push = cap & hit`.
- When `cap & ~hit`: `rej_cnt` increments, saturating at 255, and the FIFO is untouched.
- Storage: a DEPTH-entry array of {id, data}, with a write pointer and a read pointer (each AW bits, wrapping modulo DEPTH) plus `count`.
- `do_pop = pop & out_valid`. A pop while empty is ignored, with no pointer or count change.
- Push when not full: write at the write pointer, then increment the write pointer.
- Push when full (`count == DEPTH`):
  - If `do_pop` is also asserted: the pop frees a slot, the push is written, and `count` stays at DEPTH with no overflow.
  - Otherwise: the new frame is dropped (drop-newest), stored contents are unchanged, and `overflow` is set to 1.
- Push and `pop` together while empty: the push is stored, the pop is ignored, and `count` becomes 1.
- `count` update: +1 on push only, −1 on `do_pop` only, unchanged when both or neither occur.
- `overflow` is sticky. `clr_ovf` clears it to 0. If `clr_ovf` and a new overflow occur in the same cycle, set wins and `overflow` stays 1.
- Outputs:
  - `out_valid = (count != 0)`.
  - `out_id`/`out_data` are driven from the entry at the read pointer, gated to 0 when empty.
  - Output fields change only in response to a push into an empty FIFO or a pop.
- Reset:
  - Synchronous reset clears `v_d`, both pointers, `count`, `overflow` and `rej_cnt`.
  - It discards any stored frames immediately, mid-stream.
  - Array contents need not be cleared.
- Reset values: `out_valid` 0, `out_id` 0, `out_data` 0, `count` 0, `overflow` 0, `rej_cnt` 0.

## Timing
- Capture latency: with the `in_valid` rising edge sampled at edge N, the entry is written at edge N. From edge N onward, `count` and `out_valid` reflect the entry, and if the FIFO was empty, `out_id`/`out_data` show it in the same cycle after edge N. Total latency is one cycle.
- Pop: with `pop` high at edge N, the next entry (or zeros if the FIFO is now empty) is presented after edge N.
- Back-to-back pops, one per cycle, drain the FIFO at full rate.
- Back-to-back captures require `in_valid` to return low for at least one cycle between frames.
- Statistics: `rej_cnt` and `overflow` update at the same edge as the corresponding `cap`.
- There are no combinational paths from `in_*` to `out_*`. `pop` reaches the outputs only through registered state.

## Test plan
- Loopback with `can_tx`, `acc_mask=0`: one frame with ID 0x123, data 0xA5 gives `out_valid`=1, `out_id`=0x123, `out_data`=0xA5, `count`=1. After `pop`, `out_valid`=0, outputs read 0, and `rej_cnt`=0.
- Filter, `acc_code=0x120`, `acc_mask=0x7F0`:
  - IDs 0x12F and 0x123 are stored, in that order.
  - ID 0x223 is rejected: `count`=2 and `rej_cnt`=1.
  - Pops return 0x12F, then 0x123.
- Overflow, DEPTH=4: push 5 accepted frames with data 0x01..0x05 and no pops. Result is `count`=4 and `overflow`=1, and pops return 0x01..0x04 only. Pulsing `clr_ovf` returns `overflow` to 0.
- Boundary: push while full with `pop` in the same cycle keeps `count`=4 with `overflow`=0, and the new frame appears last. Push with `pop` while empty gives `count`=1. `pop` on empty leaves `count`=0.
- Level handling: `in_valid` held high for 10 cycles stores exactly one entry. 300 rejected frames leave `rej_cnt`=255.
- Reset mid-operation: with 3 entries stored, asserting `rst` for 1 cycle gives `count`=0, `out_valid`=0, `overflow`=0 and `rej_cnt`=0 at the next edge. A subsequent frame is stored normally at entry 0.

Source files
------------

// File: rtl/can_rx_filter_fifo.sv
// can_rx_filter_fifo: captures frames on in_valid rising edge, applies code/mask filter,
// buffers accepted frames in a first-word-fall-through FIFO with overflow/reject statistics.
module can_rx_filter_fifo #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [10:0]   in_id,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    input  logic [10:0]   acc_code,
    input  logic [10:0]   acc_mask,
    input  logic          pop,
    output logic [10:0]   out_id,
    output logic [7:0]    out_data,
    output logic          out_valid,
    output logic [AW:0]   count,
    output logic          overflow,
    input  logic          clr_ovf,
    output logic [7:0]    rej_cnt
);
    localparam logic [AW:0] full_cnt = (AW+1)'(DEPTH);

    logic [18:0]   mem [DEPTH];
    logic [AW-1:0] wr, rd;
    logic          v_d, cap, hit, push, full, do_pop, wr_en, drop;

    always_comb begin
        cap    = in_valid & ~v_d;
        hit    = ((in_id ^ acc_code) & acc_mask) == 11'd0;
        push   = cap & hit;
        full   = count == full_cnt;
        do_pop = pop & out_valid;
        // a simultaneous pop frees the slot, so a full FIFO can still accept
        wr_en  = push & (~full | do_pop);
        drop   = push & full & ~do_pop;
    end

    always_ff @(posedge clk)
        if (wr_en) mem[wr] <= {in_id, in_data};

    always_ff @(posedge clk) begin
        if (rst) begin
            v_d      <= 1'b0;
            wr       <= '0;
            rd       <= '0;
            count    <= '0;
            overflow <= 1'b0;
            rej_cnt  <= 8'd0;
        end else begin
            v_d <= in_valid;
            if (wr_en) wr <= wr + AW'(1);
            if (do_pop) rd <= rd + AW'(1);
            count <= (wr_en && !do_pop) ? count + (AW+1)'(1) :
                     (!wr_en && do_pop) ? count - (AW+1)'(1) : count;
            overflow <= drop ? 1'b1 : clr_ovf ? 1'b0 : overflow;
            if (cap && !hit && rej_cnt != 8'hFF) rej_cnt <= rej_cnt + 8'd1;
        end
    end

    assign out_valid = count != '0;
    assign out_id    = out_valid ? mem[rd][18:8] : 11'd0;
    assign out_data  = out_valid ? mem[rd][7:0]  : 8'd0;
endmodule

// File: tb/tb_can_rx_filter_fifo.sv
// tb_can_rx_filter_fifo: directed test-plan scenarios plus randomized traffic against a queue-based model.
module tb_can_rx_filter_fifo;
    localparam int DEPTH = 4;
    logic clk = 0, rst = 1;
    logic [10:0] in_id = 0, acc_code = 0, acc_mask = 0, out_id;
    logic [7:0] in_data = 0, out_data, rej_cnt;
    logic in_valid = 0, pop = 0, clr_ovf = 0, out_valid, overflow;
    logic [2:0] count;
    int checks = 0, errors = 0;

    logic [18:0] q[$];
    logic m_pv = 0, m_ovf = 0;
    int m_rej = 0;

    can_rx_filter_fifo #(.DEPTH(DEPTH), .AW(2)) dut (
        .clk(clk), .rst(rst), .in_id(in_id), .in_data(in_data), .in_valid(in_valid),
        .acc_code(acc_code), .acc_mask(acc_mask), .pop(pop), .out_id(out_id),
        .out_data(out_data), .out_valid(out_valid), .count(count), .overflow(overflow),
        .clr_ovf(clr_ovf), .rej_cnt(rej_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model();
        bit c, h, pp, acc, dropped;
        if (rst) begin
            q.delete();
            m_pv = 0; m_ovf = 0; m_rej = 0;
            return;
        end
        c = in_valid && !m_pv;
        h = ((in_id ^ acc_code) & acc_mask) == 0;
        pp = pop && q.size() > 0;
        acc = c && h;
        dropped = acc && q.size() == DEPTH && !pp;
        if (pp) void'(q.pop_front());
        if (acc && !dropped) q.push_back({in_id, in_data});
        if (dropped) m_ovf = 1; else if (clr_ovf) m_ovf = 0;
        if (c && !h && m_rej < 255) m_rej++;
        m_pv = in_valid;
    endtask

    task automatic tick();
        logic [18:0] head;
        @(posedge clk);
        model();
        @(negedge clk);
        head = q.size() != 0 ? q[0] : 19'd0;
        chk("out_valid", out_valid, q.size() != 0);
        chk("count", count, q.size());
        chk("out_id", out_id, head[18:8]);
        chk("out_data", out_data, head[7:0]);
        chk("overflow", overflow, m_ovf);
        chk("rej_cnt", rej_cnt, m_rej);
    endtask

    task automatic send(input logic [10:0] id, input logic [7:0] d);
        in_id = id; in_data = d; in_valid = 1;
        tick();
        in_valid = 0;
        tick();
    endtask

    task automatic do_pop();
        pop = 1; tick(); pop = 0;
    endtask

    initial begin
        tick(); tick();
        rst = 0;
        tick();
        chk("reset_count", count, 0);
        chk("reset_valid", out_valid, 0);

        // loopback, accept-all
        send(11'h123, 8'hA5);
        chk("lb_id", out_id, 11'h123);
        chk("lb_data", out_data, 8'hA5);
        chk("lb_count", count, 1);
        do_pop();
        chk("lb_empty", out_valid, 0);
        chk("lb_id0", out_id, 0);
        chk("lb_rej", rej_cnt, 0);

        // filter
        acc_code = 11'h120; acc_mask = 11'h7F0;
        send(11'h12F, 8'h11); send(11'h123, 8'h22); send(11'h223, 8'h33);
        chk("flt_count", count, 2);
        chk("flt_rej", rej_cnt, 1);
        chk("flt_head0", out_id, 11'h12F);
        do_pop();
        chk("flt_head1", out_id, 11'h123);
        do_pop();

        // overflow drop-newest
        acc_mask = 0;
        for (int i = 1; i <= 5; i++) send(11'h050, 8'(i));
        chk("ovf_count", count, 4);
        chk("ovf_flag", overflow, 1);
        for (int i = 1; i <= 4; i++) begin
            chk("ovf_order", out_data, i);
            do_pop();
        end
        clr_ovf = 1; tick(); clr_ovf = 0;
        chk("ovf_clr", overflow, 0);

        // push with pop while full
        for (int i = 0; i < 4; i++) send(11'h060, 8'(8'h10 + i));
        in_id = 11'h061; in_data = 8'h14; in_valid = 1; pop = 1;
        tick();
        in_valid = 0; pop = 0;
        tick();
        chk("full_pp_count", count, 4);
        chk("full_pp_ovf", overflow, 0);
        for (int i = 1; i <= 4; i++) begin
            chk("full_pp_order", out_data, 8'h10 + i);
            do_pop();
        end
        // push with pop while empty, then pop on empty
        in_id = 11'h070; in_data = 8'h77; in_valid = 1; pop = 1;
        tick();
        in_valid = 0; pop = 0;
        chk("empty_pp_count", count, 1);
        do_pop();
        do_pop();
        chk("empty_pop_count", count, 0);

        // level held
        in_valid = 1; in_id = 11'h0AA;
        repeat (10) tick();
        in_valid = 0; tick();
        chk("level_count", count, 1);
        do_pop();

        // reject saturation
        acc_code = 0; acc_mask = 11'h7FF;
        repeat (300) send(11'h001, 8'h00);
        chk("rej_sat", rej_cnt, 255);

        // reset mid-operation
        acc_mask = 0;
        send(11'h101, 8'h01); send(11'h102, 8'h02); send(11'h103, 8'h03);
        chk("pre_rst_count", count, 3);
        rst = 1; tick(); rst = 0;
        chk("rst_count", count, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_rej", rej_cnt, 0);
        send(11'h3C5, 8'h5A);
        chk("post_rst_id", out_id, 11'h3C5);
        chk("post_rst_data", out_data, 8'h5A);

        // in_valid held across reset release gives a single capture
        rst = 1; in_valid = 1; in_id = 11'h222; tick();
        rst = 0; repeat (3) tick();
        in_valid = 0; tick();
        chk("rst_level_count", count, 1);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            in_valid = $urandom_range(0, 1);
            in_id = 11'($urandom);
            in_data = 8'($urandom);
            pop = $urandom_range(0, 2) == 0;
            clr_ovf = $urandom_range(0, 15) == 0;
            rst = $urandom_range(0, 199) == 0;
            if ($urandom_range(0, 31) == 0) begin
                acc_code = 11'($urandom);
                acc_mask = $urandom_range(0, 2) == 0 ? 11'h000 : 11'($urandom) & 11'h700;
            end
            tick();
        end
        rst = 0; pop = 0; in_valid = 0; clr_ovf = 0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
